// File: rtl/vcpu_sm_pkg.sv
// Shared definitions for the shift-merge unit: operation codes and the
// control fields carried alongside the data through the pipeline.
package vcpu_sm_pkg;

    typedef enum logic [1:0] {
        SM_EXTR = 2'd0,
        SM_DEP  = 2'd1,
        SM_DSR  = 2'd2,
        SM_MASK = 2'd3
    } sm_op_e;

    typedef struct packed {
        sm_op_e op;
        logic   flag;
        logic   err;
    } sm_ctrl_t;

endpackage

// File: rtl/sm_field_mask.sv
// Field mask generator: ones in MSB-numbered bits lft..rht (bit 0 is the MSB).
module sm_field_mask #(
    parameter int WIDTH = 32,
    parameter int LR_W  = $clog2(WIDTH) + 2
) (
    input  logic [LR_W-1:0]  lft,
    input  logic [LR_W-1:0]  rht,
    output logic [WIDTH-1:0] mask
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign mask[WIDTH-1-gi] = (lft <= LR_W'(gi)) && (LR_W'(gi) <= rht);
        end
    endgenerate

endmodule

// File: rtl/shift_merge_pipe.sv
// Pipelined extract / deposit / double-shift-right / mask unit with a
// valid/ready handshake; stages hold under backpressure and bubbles collapse.
module shift_merge_pipe
    import vcpu_sm_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int POS_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [1:0]       in_op,
    input  logic             in_flag,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [POS_W-1:0] in_pos,
    input  logic [POS_W:0]   in_len,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_res,
    output logic             out_err
);

    localparam int AW = POS_W + 2;

    logic             s0_vld_reg, s1_vld_reg, s2_vld_reg, out_vld_reg;
    sm_op_e           s0_op_reg;
    logic             s0_flag_reg;
    logic [WIDTH-1:0] s0_a_reg, s0_b_reg;
    logic [POS_W-1:0] s0_pos_reg;
    logic [POS_W:0]   s0_len_reg;
    sm_ctrl_t         s1_ctrl_reg, s2_ctrl_reg;
    logic [WIDTH-1:0] s1_a_reg, s1_b_reg, s1_mask_reg;
    logic [AW-1:0]    s1_sh_reg;
    logic [WIDTH-1:0] s2_val_reg, s2_msk_reg, s2_b_reg;
    logic [WIDTH-1:0] out_res_reg;
    logic             out_err_reg;

    // A stage holds only when it is full and everything downstream holds.
    logic stall, s2_hold, s1_hold, s0_hold;
    assign stall   = out_vld_reg && !out_rdy;
    assign s2_hold = s2_vld_reg && stall;
    assign s1_hold = s1_vld_reg && s2_hold;
    assign s0_hold = s0_vld_reg && s1_hold;
    assign in_rdy  = !stall && !rst;

    // S1: field check, shift amount and mask from the captured operation.
    logic [AW-1:0]    pos_x, len_x, lft_x, sh_next;
    logic             field_err, err_next;
    logic [WIDTH-1:0] mask_w;
    sm_ctrl_t         s1_ctrl_next;

    assign pos_x     = AW'(s0_pos_reg);
    assign len_x     = AW'(s0_len_reg);
    assign lft_x     = pos_x - len_x + AW'(1);
    // A position beyond the datapath (non power-of-two WIDTH) is also illegal.
    assign field_err = (len_x == '0) || (len_x > pos_x + AW'(1)) || (pos_x >= AW'(WIDTH));

    sm_field_mask #(.WIDTH(WIDTH), .LR_W(AW)) u_field_mask (
        .lft  (lft_x),
        .rht  (pos_x),
        .mask (mask_w)
    );

    always_comb begin
        err_next = field_err;
        sh_next  = '0;
        case (s0_op_reg)
            SM_EXTR, SM_DEP: sh_next = AW'(WIDTH - 1) - pos_x;
            SM_DSR: begin
                err_next = len_x > AW'(WIDTH);
                sh_next  = len_x;
            end
            default: ;
        endcase
        s1_ctrl_next.op   = s0_op_reg;
        s1_ctrl_next.flag = s0_flag_reg;
        s1_ctrl_next.err  = err_next;
    end

    // S2: EXTR moves field and mask down to the LSB end, DEP moves A up.
    logic [WIDTH-1:0] dsr_low, val_next, msk_next;
    assign dsr_low = WIDTH'({s1_a_reg, s1_b_reg} >> s1_sh_reg);

    always_comb begin
        val_next = '0;
        msk_next = s1_mask_reg;
        case (s1_ctrl_reg.op)
            SM_EXTR: begin
                val_next = s1_a_reg >> s1_sh_reg;
                msk_next = s1_mask_reg >> s1_sh_reg;
            end
            SM_DEP:  val_next = s1_a_reg << s1_sh_reg;
            SM_DSR:  val_next = dsr_low;
            default: ;
        endcase
    end

    // S3: merge / fill; the sign of an extracted field is its top mask bit.
    logic [WIDTH-1:0] field_w, top_bit_w, res_next;
    logic             sign_w;
    assign field_w   = s2_val_reg & s2_msk_reg;
    assign top_bit_w = s2_msk_reg & ~(s2_msk_reg >> 1);
    assign sign_w    = |(s2_val_reg & top_bit_w);

    always_comb begin
        res_next = '0;
        case (s2_ctrl_reg.op)
            SM_EXTR: res_next = field_w | ((s2_ctrl_reg.flag && sign_w) ? ~s2_msk_reg : '0);
            SM_DEP:  res_next = field_w | (s2_ctrl_reg.flag ? '0 : (s2_b_reg & ~s2_msk_reg));
            SM_DSR:  res_next = s2_val_reg;
            SM_MASK: res_next = s2_msk_reg;
            default: ;
        endcase
        if (s2_ctrl_reg.err) begin
            res_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_vld_reg  <= 1'b0;
            s1_vld_reg  <= 1'b0;
            s2_vld_reg  <= 1'b0;
            out_vld_reg <= 1'b0;
            out_res_reg <= '0;
            out_err_reg <= 1'b0;
        end else begin
            if (!s0_hold) s0_vld_reg <= in_vld && in_rdy;
            if (!s1_hold) s1_vld_reg <= s0_vld_reg;
            if (!s2_hold) s2_vld_reg <= s1_vld_reg;
            if (!stall) begin
                out_vld_reg <= s2_vld_reg;
                if (s2_vld_reg) begin
                    out_res_reg <= res_next;
                    out_err_reg <= s2_ctrl_reg.err;
                end
            end
        end
    end

    // Payload registers need no reset: the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (!s0_hold) begin
            s0_op_reg   <= sm_op_e'(in_op);
            s0_flag_reg <= in_flag;
            s0_a_reg    <= in_a;
            s0_b_reg    <= in_b;
            s0_pos_reg  <= in_pos;
            s0_len_reg  <= in_len;
        end
        if (!s1_hold) begin
            s1_ctrl_reg <= s1_ctrl_next;
            s1_a_reg    <= s0_a_reg;
            s1_b_reg    <= s0_b_reg;
            s1_mask_reg <= mask_w;
            s1_sh_reg   <= sh_next;
        end
        if (!s2_hold) begin
            s2_ctrl_reg <= s1_ctrl_reg;
            s2_val_reg  <= val_next;
            s2_msk_reg  <= msk_next;
            s2_b_reg    <= s1_b_reg;
        end
    end

    assign out_vld = out_vld_reg;
    assign out_res = out_res_reg;
    assign out_err = out_err_reg;

endmodule

// File: tb/tb_shift_merge_pipe.sv
// Self-checking bench for shift_merge_pipe: directed vectors, backpressure,
// mid-flight reset and randomized traffic against a bit-level reference model.
module tb_shift_merge_pipe;

    localparam logic [1:0] OP_EXTR = 2'd0;
    localparam logic [1:0] OP_DEP  = 2'd1;
    localparam logic [1:0] OP_DSR  = 2'd2;
    localparam logic [1:0] OP_MASK = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_vld = 1'b0, in_flag = 1'b0, out_rdy = 1'b1;
    logic        in_rdy, out_vld, out_err;
    logic [1:0]  in_op = 2'd0;
    logic [31:0] in_a = '0, in_b = '0, out_res;
    logic [4:0]  in_pos = '0;
    logic [5:0]  in_len = '0;

    logic        in_vld24 = 1'b0, in_flag24 = 1'b0, out_rdy24 = 1'b1;
    logic        in_rdy24, out_vld24, out_err24;
    logic [1:0]  in_op24 = 2'd0;
    logic [23:0] in_a24 = '0, in_b24 = '0, out_res24;
    logic [4:0]  in_pos24 = '0;
    logic [5:0]  in_len24 = '0;

    int errors = 0;
    int checks = 0;
    logic [32:0] exp_q[$];
    logic [32:0] got_q[$];

    shift_merge_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_op(in_op),
        .in_flag(in_flag), .in_a(in_a), .in_b(in_b), .in_pos(in_pos), .in_len(in_len),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_res(out_res), .out_err(out_err)
    );

    shift_merge_pipe #(.WIDTH(24)) dut24 (
        .clk(clk), .rst(rst), .in_vld(in_vld24), .in_rdy(in_rdy24), .in_op(in_op24),
        .in_flag(in_flag24), .in_a(in_a24), .in_b(in_b24), .in_pos(in_pos24), .in_len(in_len24),
        .out_vld(out_vld24), .out_rdy(out_rdy24), .out_res(out_res24), .out_err(out_err24)
    );

    always #5 clk = ~clk;

    // Record every output transfer; comparisons happen in the test tasks.
    always @(negedge clk) begin
        if (out_vld === 1'b1 && out_rdy === 1'b1) got_q.push_back({out_err, out_res});
    end

    // Reference model over MSB-numbered bits: bit i of x is x[31-i].
    function automatic logic [32:0] model(input logic [1:0] op, input logic flag,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input int pos, input int len);
        logic [31:0] r;
        logic [63:0] cat;
        int lft;
        r   = '0;
        lft = pos - len + 1;
        if (op == OP_DSR) begin
            if (len > 32) return {1'b1, 32'h0};
            cat = {a, b} >> len;
            return {1'b0, cat[31:0]};
        end
        if (len == 0 || len > pos + 1) return {1'b1, 32'h0};
        for (int i = 0; i < 32; i++) begin
            case (op)
                OP_EXTR: r[31-i] = (i < 32 - len) ? (flag & a[31-lft]) : a[31-(lft + i - (32 - len))];
                OP_DEP:  r[31-i] = (i >= lft && i <= pos) ? a[len-1-(i-lft)] : (!flag & b[31-i]);
                default: r[31-i] = (i >= lft && i <= pos);
            endcase
        end
        return {1'b0, r};
    endfunction

    task automatic send(input logic [1:0] op, input logic flag, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] pos, input logic [5:0] len);
        bit ok = 1'b0;
        in_op = op; in_flag = flag; in_a = a; in_b = b; in_pos = pos; in_len = len; in_vld = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = (in_rdy === 1'b1);
            @(posedge clk); #1;
        end
        in_vld = 1'b0;
        if (ok) exp_q.push_back(model(op, flag, a, b, int'(pos), int'(len)));
        else begin
            checks++; errors++;
            $display("FAIL send_timeout: in_rdy=0 for 200 cycles, required 1");
        end
    endtask

    task automatic run_one(input logic [1:0] op, input logic flag, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] pos, input logic [5:0] len,
                           output logic [32:0] got);
        send(op, flag, a, b, pos, len);
        got = 'x;
        for (int t = 0; t < 20 && got_q.size() == 0; t++) begin @(posedge clk); #1; end
        if (got_q.size() > 0) got = got_q.pop_front();
        exp_q.delete();
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 400 && got_q.size() < exp_q.size(); t++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 4;
        if (in_rdy !== 1'b0) begin errors++; $display("FAIL reset_in_rdy: got %b, required 0", in_rdy); end
        if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld: got %b, required 0", out_vld); end
        if (out_res !== 32'h0) begin errors++; $display("FAIL reset_out_res: got %h, required 0", out_res); end
        if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err: got %b, required 0", out_err); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_rdy !== 1'b1) begin errors++; $display("FAIL post_reset_in_rdy: got %b, required 1", in_rdy); end
        @(posedge clk); #1;
    endtask

    task automatic test_extr();
        logic [32:0] g;
        send(OP_EXTR, 1'b0, 32'h1234F678, 32'h0, 5'd23, 6'd8);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (out_vld !== (k == 3)) begin
                errors++;
                $display("FAIL extr_latency: cycle %0d after accept out_vld=%b, required %b", k, out_vld, k == 3);
            end
        end
        @(posedge clk); #1;
        g = (got_q.size() > 0) ? got_q.pop_front() : 33'bx;
        exp_q.delete();
        checks++;
        if (g !== {1'b0, 32'h000000F6}) begin errors++; $display("FAIL extr_zero: got err=%b res=%h, required err=0 res=000000f6", g[32], g[31:0]); end
        run_one(OP_EXTR, 1'b1, 32'h1234F678, 32'h0, 5'd23, 6'd8, g);
        checks++;
        if (g !== {1'b0, 32'hFFFFFFF6}) begin errors++; $display("FAIL extr_sign: got err=%b res=%h, required err=0 res=fffffff6", g[32], g[31:0]); end
    endtask

    task automatic test_dep();
        logic [32:0] g;
        run_one(OP_DEP, 1'b0, 32'h000000AB, 32'hFFFFFFFF, 5'd15, 6'd8, g);
        checks++;
        if (g !== {1'b0, 32'hFFABFFFF}) begin errors++; $display("FAIL dep_merge: got err=%b res=%h, required err=0 res=ffabffff", g[32], g[31:0]); end
        run_one(OP_DEP, 1'b1, 32'h000000AB, 32'hFFFFFFFF, 5'd15, 6'd8, g);
        checks++;
        if (g !== {1'b0, 32'h00AB0000}) begin errors++; $display("FAIL dep_zero: got err=%b res=%h, required err=0 res=00ab0000", g[32], g[31:0]); end
    endtask

    task automatic test_dsr();
        logic [5:0]  lens [4] = '{6'd4, 6'd0, 6'd32, 6'd33};
        logic [32:0] want [4] = '{{1'b0, 32'h10000000}, {1'b0, 32'h0}, {1'b0, 32'h1}, {1'b1, 32'h0}};
        logic [32:0] g;
        for (int i = 0; i < 4; i++) begin
            run_one(OP_DSR, 1'b0, 32'h00000001, 32'h0, 5'd0, lens[i], g);
            checks++;
            if (g !== want[i]) begin
                errors++;
                $display("FAIL dsr_len%0d: got err=%b res=%h, required err=%b res=%h", lens[i], g[32], g[31:0], want[i][32], want[i][31:0]);
            end
        end
    endtask

    task automatic test_mask();
        logic [4:0]  poss [3] = '{5'd9, 5'd9, 5'd3};
        logic [5:0]  lens [3] = '{6'd10, 6'd0, 6'd5};
        logic [32:0] want [3] = '{{1'b0, 32'hFFC00000}, {1'b1, 32'h0}, {1'b1, 32'h0}};
        logic [32:0] g;
        for (int i = 0; i < 3; i++) begin
            run_one(OP_MASK, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A, poss[i], lens[i], g);
            checks++;
            if (g !== want[i]) begin
                errors++;
                $display("FAIL mask_p%0d_l%0d: got err=%b res=%h, required err=%b res=%h", poss[i], lens[i], g[32], g[31:0], want[i][32], want[i][31:0]);
            end
        end
    endtask

    task automatic test_mask_w24();
        logic [5:0]  lens [2] = '{6'd24, 6'd0};
        logic [24:0] want [2] = '{{1'b0, 24'hFFFFFF}, {1'b1, 24'h0}};
        logic [24:0] g;
        bit seen;
        for (int i = 0; i < 2; i++) begin
            in_op24 = OP_MASK; in_pos24 = 5'd23; in_len24 = lens[i]; in_vld24 = 1'b1;
            @(negedge clk);
            checks++;
            if (in_rdy24 !== 1'b1) begin errors++; $display("FAIL w24_in_rdy: got %b, required 1", in_rdy24); end
            @(posedge clk); #1;
            in_vld24 = 1'b0;
            seen = 1'b0;
            g = 'x;
            for (int t = 0; t < 10 && !seen; t++) begin
                @(negedge clk);
                if (out_vld24 === 1'b1) begin seen = 1'b1; g = {out_err24, out_res24}; end
            end
            @(posedge clk); #1;
            checks++;
            if (g !== want[i]) begin
                errors++;
                $display("FAIL w24_mask_l%0d: got err=%b res=%h, required err=%b res=%h", lens[i], g[24], g[23:0], want[i][24], want[i][23:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [32:0] held, e, g;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(OP_EXTR, 1'(i), $urandom, $urandom, 5'(16 + i), 6'(3 + i));
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_rdy = 1'b0;
                held = 'x;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    if (k == 0) held = {out_err, out_res};
                    checks += 2;
                    if (out_vld !== 1'b1) begin errors++; $display("FAIL bp_out_vld: stall cycle %0d got %b, required 1", k, out_vld); end
                    if (in_rdy !== 1'b0) begin errors++; $display("FAIL bp_in_rdy: stall cycle %0d got %b, required 0", k, in_rdy); end
                    if (k > 0) begin
                        checks++;
                        if ({out_err, out_res} !== held) begin
                            errors++;
                            $display("FAIL bp_hold: stall cycle %0d res=%h, required %h", k, out_res, held[31:0]);
                        end
                    end
                    @(posedge clk); #1;
                end
                out_rdy = 1'b1;
            end
        join
        wait_drain();
        checks++;
        if (got_q.size() !== 6 || exp_q.size() !== 6) begin
            errors++;
            $display("FAIL bp_count: got %0d results, required 6", got_q.size());
        end
        for (int i = 0; exp_q.size() > 0 && got_q.size() > 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL bp_result%0d: got err=%b res=%h, required err=%b res=%h", i, g[32], g[31:0], e[32], e[31:0]); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_random();
        bit done = 1'b0;
        int n_exp;
        logic [32:0] e, g;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    logic [1:0] op = 2'($urandom_range(0, 3));
                    int pos = $urandom_range(0, 31);
                    int len = (op == OP_DSR) ? $urandom_range(0, 33) : $urandom_range(0, pos + 2);
                    send(op, 1'($urandom_range(0, 1)), $urandom, $urandom, 5'(pos), 6'(len));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_rdy = ($urandom_range(0, 3) != 0);
                end
                out_rdy = 1'b1;
            end
        join
        wait_drain();
        n_exp = exp_q.size();
        checks++;
        if (got_q.size() !== n_exp) begin errors++; $display("FAIL rand_count: got %0d results, required %0d", got_q.size(), n_exp); end
        for (int i = 0; exp_q.size() > 0 && got_q.size() > 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL rand_result%0d: got err=%b res=%h, required err=%b res=%h", i, g[32], g[31:0], e[32], e[31:0]); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset_midflight();
        logic [32:0] g;
        out_rdy = 1'b1;
        send(OP_MASK, 1'b0, 32'h0, 32'h0, 5'd31, 6'd32);
        send(OP_DSR, 1'b0, 32'h12345678, 32'h9ABCDEF0, 5'd0, 6'd8);
        send(OP_DEP, 1'b0, 32'hFF, 32'h0, 5'd7, 6'd8);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checks += 2;
        if (out_vld !== 1'b0) begin errors++; $display("FAIL midrst_out_vld: got %b, required 0", out_vld); end
        if (out_res !== 32'h0) begin errors++; $display("FAIL midrst_out_res: got %h, required 0", out_res); end
        @(posedge clk); #1;
        send(OP_DSR, 1'b0, 32'hDEADBEEF, 32'h0, 5'd0, 6'd32);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (out_vld !== (k == 3)) begin
                errors++;
                $display("FAIL midrst_latency: cycle %0d after accept out_vld=%b, required %b", k, out_vld, k == 3);
            end
        end
        @(posedge clk); #1;
        g = (got_q.size() > 0) ? got_q.pop_front() : 33'bx;
        exp_q.delete();
        checks++;
        if (g !== {1'b0, 32'hDEADBEEF}) begin errors++; $display("FAIL midrst_new_op: got err=%b res=%h, required err=0 res=deadbeef", g[32], g[31:0]); end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() !== 0) begin errors++; $display("FAIL midrst_stale: %0d extra results emerged, required 0", got_q.size()); end
        got_q.delete();
    endtask

    initial begin
        test_reset();
        test_extr();
        test_dep();
        test_dsr();
        test_mask();
        test_mask_w24();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
